control_fsm: RTL and testbench

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/control_fsm_if.sv | 33 +++
 rtl/control_fsm.sv | 144 ++++++++++++++
 tb/tb_control_fsm.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/control_fsm_if.sv
// Bus bundle between the control FSM and the datapath/system bus.
// master = control FSM, slave = datapath side.
interface control_fsm_if;
    logic [4:0]  Opcode;
    logic        MemReady;
    logic        CFlag;
    logic [3:0]  AluFunc;
    logic [1:0]  PcSel;
    logic [1:0]  Op1Sel;
    logic [1:0]  ImmSel;
    logic        CarryIn;
    logic        MemRead;
    logic        IrWe;
    logic        PcWe;
    logic        RegWe;
    logic        CFlagWe;
    logic        Illegal;
    logic [15:0] Retired;

    modport master (
        input  Opcode, MemReady, CFlag,
        output AluFunc, PcSel, Op1Sel, ImmSel, CarryIn,
        output MemRead, IrWe, PcWe, RegWe, CFlagWe,
        output Illegal, Retired
    );

    modport slave (
        output Opcode, MemReady, CFlag,
        input  AluFunc, PcSel, Op1Sel, ImmSel, CarryIn,
        input  MemRead, IrWe, PcWe, RegWe, CFlagWe,
        input  Illegal, Retired
    );
endinterface

// File: rtl/control_fsm.sv
// Three-state FETCH/DECODE/EXECUTE control unit.
// Strobes come from the state plus a control word latched in DECODE.
module control_fsm (
    input  logic       Clock,
    input  logic       Reset,
    control_fsm_if.master bus
);
    localparam logic [3:0] FnNop = 4'd0;
    localparam logic [3:0] FnAdd = 4'd3;

    localparam logic [1:0] PcOne  = 2'd3;
    localparam logic [1:0] Op1Pc  = 2'd0;
    localparam logic [1:0] Op1Rd1 = 2'd1;

    typedef enum logic [1:0] {
        Fetch   = 2'd0,
        Decode  = 2'd1,
        Execute = 2'd2
    } stateT;

    typedef struct packed {
        logic [3:0] aluFunc;
        logic [1:0] immSel;
        logic       useCarry;
        logic       regWr;
        logic       illegal;
    } ctrlWordT;

    localparam ctrlWordT NopWord = '{
        aluFunc:  FnNop,
        immSel:   2'd0,
        useCarry: 1'b0,
        regWr:    1'b0,
        illegal:  1'b0
    };

    stateT       stateQ, stateD;
    ctrlWordT    ctrlQ, ctrlD;
    logic        illegalQ;
    logic [15:0] retiredQ;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            stateQ   <= Fetch;
            ctrlQ    <= NopWord;
            illegalQ <= 1'b0;
            retiredQ <= 16'h0000;
        end else begin
            stateQ <= stateD;
            ctrlQ  <= ctrlD;
            if (stateQ == Execute) begin
                retiredQ <= retiredQ + 16'd1;
                if (ctrlQ.illegal)
                    illegalQ <= 1'b1;
            end
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            Fetch:   if (bus.MemReady) stateD = Decode;
            Decode:  stateD = Execute;
            Execute: stateD = Fetch;
            default: stateD = Fetch;
        endcase
    end

    // The control word is only re-sampled in DECODE; it holds otherwise.
    always_comb begin
        ctrlD = ctrlQ;
        if (stateQ == Decode) begin
            ctrlD = NopWord;
            unique case (bus.Opcode)
                5'b00000: ctrlD = NopWord;
                5'b00100: begin
                    ctrlD.aluFunc = FnAdd;
                    ctrlD.regWr   = 1'b1;
                end
                5'b00101: begin
                    ctrlD.aluFunc = FnAdd;
                    ctrlD.immSel  = 2'd1;
                    ctrlD.regWr   = 1'b1;
                end
                5'b11000: begin
                    ctrlD.aluFunc = FnAdd;
                    ctrlD.immSel  = 2'd2;
                    ctrlD.regWr   = 1'b1;
                end
                5'b00110: begin
                    ctrlD.aluFunc  = FnAdd;
                    ctrlD.useCarry = 1'b1;
                    ctrlD.regWr    = 1'b1;
                end
                5'b00111: begin
                    ctrlD.aluFunc  = FnAdd;
                    ctrlD.immSel   = 2'd1;
                    ctrlD.useCarry = 1'b1;
                    ctrlD.regWr    = 1'b1;
                end
                default: ctrlD.illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        bus.AluFunc = FnNop;
        bus.PcSel   = PcOne;
        bus.Op1Sel  = Op1Pc;
        bus.ImmSel  = 2'd0;
        bus.CarryIn = 1'b0;
        bus.MemRead = 1'b0;
        bus.IrWe    = 1'b0;
        bus.PcWe    = 1'b0;
        bus.RegWe   = 1'b0;
        bus.CFlagWe = 1'b0;
        unique case (stateQ)
            Fetch: begin
                if (!Reset) begin
                    bus.MemRead = 1'b1;
                    bus.IrWe    = bus.MemReady;
                    bus.PcWe    = bus.MemReady;
                end
            end
            Decode: begin
            end
            Execute: begin
                bus.AluFunc = ctrlQ.aluFunc;
                bus.ImmSel  = ctrlQ.immSel;
                // Live flag, so a carry written by the previous add is seen.
                bus.CarryIn = ctrlQ.useCarry & bus.CFlag;
                bus.RegWe   = ctrlQ.regWr;
                bus.CFlagWe = ctrlQ.regWr;
                if (ctrlQ.regWr)
                    bus.Op1Sel = Op1Rd1;
            end
            default: begin
            end
        endcase
    end

    assign bus.Illegal = illegalQ | ((stateQ == Execute) & ctrlQ.illegal);
    assign bus.Retired = retiredQ;
endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: decode table, stalls, carry pass-through,
// sticky illegal flag, Retired wrap and mid-instruction reset.
module tb_control_fsm;
    logic Clock;
    logic Reset;
    int   nChecks;
    int   nFails;
    int   expRet;

    control_fsm_if bus ();

    control_fsm dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.master)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs FETCH (with stalls) and DECODE; returns #1 into EXECUTE.
    task automatic goExecute(input logic [4:0] op, input int waits);
        bus.Opcode   = op;
        bus.MemReady = 1'b0;
        for (int i = 0; i < waits; i++) begin
            #1;
            checkVal("stallMemRead", bus.MemRead, 1);
            checkVal("stallIrWe", bus.IrWe, 0);
            checkVal("stallPcWe", bus.PcWe, 0);
            @(negedge Clock);
        end
        bus.MemReady = 1'b1;
        #1;
        checkVal("fetchMemRead", bus.MemRead, 1);
        checkVal("fetchIrWe", bus.IrWe, 1);
        checkVal("fetchPcWe", bus.PcWe, 1);
        checkVal("fetchPcSel", bus.PcSel, 3);
        checkVal("fetchOp1Sel", bus.Op1Sel, 0);
        checkVal("fetchRegWe", bus.RegWe, 0);
        @(negedge Clock);
        bus.MemReady = 1'b0;
        #1;
        checkVal("decMemRead", bus.MemRead, 0);
        checkVal("decIrWe", bus.IrWe, 0);
        checkVal("decPcWe", bus.PcWe, 0);
        checkVal("decRegWe", bus.RegWe, 0);
        checkVal("decAluFunc", bus.AluFunc, 0);
        @(negedge Clock);
        #1;
    endtask

    task automatic checkExec(input string tag, input logic [3:0] alu,
                             input logic [1:0] imm, input logic wr);
        checkVal({tag, "AluFunc"}, bus.AluFunc, alu);
        checkVal({tag, "ImmSel"}, bus.ImmSel, imm);
        checkVal({tag, "RegWe"}, bus.RegWe, wr);
        checkVal({tag, "CFlagWe"}, bus.CFlagWe, wr);
        checkVal({tag, "Op1Sel"}, bus.Op1Sel, {1'b0, wr});
        checkVal({tag, "IrWe"}, bus.IrWe, 0);
        checkVal({tag, "PcWe"}, bus.PcWe, 0);
        checkVal({tag, "MemRead"}, bus.MemRead, 0);
    endtask

    task automatic retire(input string tag);
        @(negedge Clock);
        #1;
        expRet = (expRet + 1) & 16'hFFFF;
        checkVal({tag, "Retired"}, bus.Retired, expRet);
        checkVal({tag, "backInFetch"}, bus.MemRead, 1);
    endtask

    initial begin
        nChecks      = 0;
        nFails       = 0;
        expRet       = 0;
        Reset        = 1'b1;
        bus.Opcode   = 5'b00100;
        bus.MemReady = 1'b1;
        bus.CFlag    = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        #1;
        checkVal("rstMemRead", bus.MemRead, 0);
        checkVal("rstIrWe", bus.IrWe, 0);
        checkVal("rstPcWe", bus.PcWe, 0);
        checkVal("rstPcSel", bus.PcSel, 3);
        checkVal("rstAluFunc", bus.AluFunc, 0);
        checkVal("rstIllegal", bus.Illegal, 0);
        checkVal("rstRetired", bus.Retired, 0);
        Reset = 1'b0;

        goExecute(5'b00100, 0);
        checkExec("add", 4'd3, 2'd0, 1'b1);
        checkVal("addCarryIn", bus.CarryIn, 0);
        retire("add");

        goExecute(5'b11000, 4);
        checkExec("addib", 4'd3, 2'd2, 1'b1);
        retire("addib");

        goExecute(5'b00110, 0);
        checkExec("adc", 4'd3, 2'd0, 1'b1);
        bus.CFlag = 1'b1;
        #1;
        checkVal("adcCarry1", bus.CarryIn, 1);
        bus.CFlag = 1'b0;
        #1;
        checkVal("adcCarry0", bus.CarryIn, 0);
        retire("adc");

        goExecute(5'b00111, 0);
        checkExec("adci", 4'd3, 2'd1, 1'b1);
        bus.CFlag = 1'b1;
        #1;
        checkVal("adciCarry1", bus.CarryIn, 1);
        bus.CFlag = 1'b0;
        #1;
        checkVal("adciCarry0", bus.CarryIn, 0);
        retire("adci");

        bus.CFlag = 1'b1;
        goExecute(5'b00101, 0);
        checkExec("addi", 4'd3, 2'd1, 1'b1);
        checkVal("addiCarryIn", bus.CarryIn, 0);
        retire("addi");

        goExecute(5'b00000, 0);
        checkExec("nop", 4'd0, 2'd0, 1'b0);
        checkVal("nopIllegal", bus.Illegal, 0);
        retire("nop");

        goExecute(5'b01111, 0);
        checkExec("ill", 4'd0, 2'd0, 1'b0);
        checkVal("illIllegal", bus.Illegal, 1);
        checkVal("illCarryIn", bus.CarryIn, 0);
        retire("ill");
        checkVal("illSticky", bus.Illegal, 1);

        goExecute(5'b00100, 1);
        checkExec("addAfterIll", 4'd3, 2'd0, 1'b1);
        checkVal("addAfterIllIllegal", bus.Illegal, 1);
        retire("addAfterIll");

        // Preload the counter instead of running 65535 NOPs.
        bus.MemReady = 1'b0;
        force dut.retiredQ = 16'hFFFF;
        @(posedge Clock);
        #1;
        release dut.retiredQ;
        @(negedge Clock);
        #1;
        expRet = 16'hFFFF;
        checkVal("preload", bus.Retired, 16'hFFFF);
        goExecute(5'b00000, 0);
        retire("wrap");

        goExecute(5'b00100, 0);
        checkVal("preRstRegWe", bus.RegWe, 1);
        Reset = 1'b1;
        #1;
        checkVal("midRstRegWe", bus.RegWe, 0);
        checkVal("midRstCFlagWe", bus.CFlagWe, 0);
        checkVal("midRstRetired", bus.Retired, 0);
        checkVal("midRstIllegal", bus.Illegal, 0);
        checkVal("midRstMemRead", bus.MemRead, 0);
        checkVal("midRstAluFunc", bus.AluFunc, 0);
        @(negedge Clock);
        #1;
        Reset = 1'b0;
        #1;
        checkVal("relMemRead", bus.MemRead, 1);
        checkVal("relRegWe", bus.RegWe, 0);
        @(negedge Clock);
        #1;
        checkVal("relStillFetch", bus.MemRead, 1);
        checkVal("relRetired", bus.Retired, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end
endmodule
